// File: rtl/smart_cargo_pkg.sv
// SmartCargo shared types: floor type, parser states, display codes and ASCII constants.
// Used by receptor_pedidos and fila_pedidos.
package smart_cargo_pkg;

    typedef logic [1:0] andar_t;

    localparam int ANDAR_MAX_PADRAO = 3;

    typedef enum logic [1:0] {
        ESPERA_ORIGEM  = 2'd0,
        ESPERA_DESTINO = 2'd1,
        ESPERA_FIM     = 2'd2
    } estado_t;

    localparam logic [3:0] DB_TIMEOUT = 4'd3;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_FIM  = 8'h23;

    function automatic logic eh_andar(input logic [7:0] b, input int max);
        return (b >= ASCII_ZERO) && (b <= ASCII_ZERO + 8'(max));
    endfunction

endpackage

// File: rtl/fila_pedidos.sv
// Synchronous first-word-fall-through FIFO for floor requests.
// A push while full is only dropped when no pop happens in the same cycle.
module fila_pedidos
    import smart_cargo_pkg::*;
#(
    parameter int PROFUNDIDADE = 4,
    parameter int LARGURA      = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               push,
    input  logic [LARGURA-1:0] dado_entrada,
    input  logic               pop,
    output logic [LARGURA-1:0] dado_saida,
    output logic               vazia,
    output logic               cheia,
    output logic               overflow
);

    localparam int PW = $clog2(PROFUNDIDADE);
    localparam logic [PW:0] OCUP_MAX = PROFUNDIDADE[PW:0];

    logic [LARGURA-1:0] mem [PROFUNDIDADE];
    logic [PW-1:0]      ptr_esc;
    logic [PW-1:0]      ptr_lei;
    logic [PW:0]        ocupacao;
    logic               pop_ef;
    logic               push_ef;

    assign vazia      = (ocupacao == '0);
    assign cheia      = (ocupacao == OCUP_MAX);
    assign pop_ef     = pop & ~vazia;
    assign push_ef    = push & (~cheia | pop_ef);
    assign overflow   = push & cheia & ~pop_ef;
    assign dado_saida = mem[ptr_lei];

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_esc  <= '0;
            ptr_lei  <= '0;
            ocupacao <= '0;
            for (int i = 0; i < PROFUNDIDADE; i++)
                mem[i] <= '0;
        end else begin
            if (push_ef) begin
                mem[ptr_esc] <= dado_entrada;
                ptr_esc      <= ptr_esc + 1'b1;
            end
            if (pop_ef)
                ptr_lei <= ptr_lei + 1'b1;
            case ({push_ef, pop_ef})
                2'b10:   ocupacao <= ocupacao + 1'b1;
                2'b01:   ocupacao <= ocupacao - 1'b1;
                default: ocupacao <= ocupacao;
            endcase
        end
    end

endmodule

// File: rtl/receptor_pedidos.sv
// Parses UART bytes into origin/destination/'#' requests and queues them.
// Optional inter-byte timeout: define FRAME_TIMEOUT_EN.
module receptor_pedidos
    import smart_cargo_pkg::*;
#(
    parameter int PROFUNDIDADE   = 4,
    parameter int ANDAR_MAX      = ANDAR_MAX_PADRAO,
    parameter int TIMEOUT_CICLOS = 50_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] rx_dado,
    input  logic       rx_pronto,
    output andar_t     pedido_origem,
    output andar_t     pedido_destino,
    output logic       pedido_valido,
    input  logic       pedido_aceito,
    output logic       fila_cheia,
    output logic       erro_quadro,
    output logic       fila_overflow,
    output logic [7:0] num_erros,
    output logic [3:0] db_estado
);

    if (PROFUNDIDADE < 2 || (PROFUNDIDADE & (PROFUNDIDADE - 1)) != 0
        || ANDAR_MAX > 3 || TIMEOUT_CICLOS < 2) begin : g_param_invalido
        $error("receptor_pedidos: invalid parameters");
    end

    estado_t    estado;
    estado_t    estado_ef;
    andar_t     origem;
    andar_t     destino;
    andar_t     andar_rx;
    logic       eh_digito;
    logic       eh_fim;
    logic       erro_byte;
    logic       erro_evento;
    logic       push;
    logic       overflow;
    logic       vazia;
    logic       expira;
    logic [3:0] cabeca;

`ifdef FRAME_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CICLOS);
    localparam logic [TW-1:0] LIMITE = TW'(TIMEOUT_CICLOS - 1);

    logic [TW-1:0] temporizador;

    always_ff @(posedge clock) begin
        if (reset || rx_pronto || expira || estado == ESPERA_ORIGEM)
            temporizador <= '0;
        else
            temporizador <= temporizador + 1'b1;
    end

    assign expira = (estado != ESPERA_ORIGEM) && (temporizador == LIMITE);
`else
    assign expira = 1'b0;
`endif

    // An expired frame is dropped before this cycle's byte is decoded.
    assign estado_ef = expira ? ESPERA_ORIGEM : estado;

    assign eh_digito = eh_andar(rx_dado, ANDAR_MAX);
    assign eh_fim    = (rx_dado == ASCII_FIM);
    assign andar_rx  = andar_t'(rx_dado - ASCII_ZERO);
    assign push      = rx_pronto && (estado_ef == ESPERA_FIM) && eh_fim;

    always_comb begin
        erro_byte = 1'b0;
        if (rx_pronto) begin
            unique case (estado_ef)
                ESPERA_ORIGEM:  erro_byte = !eh_digito;
                ESPERA_DESTINO: erro_byte = !eh_digito || (andar_rx == origem);
                ESPERA_FIM:     erro_byte = !eh_fim;
                default:        erro_byte = 1'b1;
            endcase
        end
    end

    assign erro_evento = erro_byte | expira;

    always_ff @(posedge clock) begin
        if (reset) begin
            estado        <= ESPERA_ORIGEM;
            origem        <= '0;
            destino       <= '0;
            erro_quadro   <= 1'b0;
            fila_overflow <= 1'b0;
            num_erros     <= '0;
        end else begin
            erro_quadro   <= erro_evento;
            fila_overflow <= overflow;
            if ((erro_evento || overflow) && num_erros != 8'hFF)
                num_erros <= num_erros + 1'b1;
            if (!rx_pronto)
                estado <= estado_ef;
            else if (erro_byte)
                estado <= ESPERA_ORIGEM;
            else begin
                unique case (estado_ef)
                    ESPERA_ORIGEM: begin
                        origem <= andar_rx;
                        estado <= ESPERA_DESTINO;
                    end
                    ESPERA_DESTINO: begin
                        destino <= andar_rx;
                        estado  <= ESPERA_FIM;
                    end
                    default: estado <= ESPERA_ORIGEM;
                endcase
            end
        end
    end

    fila_pedidos #(
        .PROFUNDIDADE(PROFUNDIDADE),
        .LARGURA     (4)
    ) u_fila (
        .clock       (clock),
        .reset       (reset),
        .push        (push),
        .dado_entrada({origem, destino}),
        .pop         (pedido_aceito),
        .dado_saida  (cabeca),
        .vazia       (vazia),
        .cheia       (fila_cheia),
        .overflow    (overflow)
    );

    assign pedido_origem  = cabeca[3:2];
    assign pedido_destino = cabeca[1:0];
    assign pedido_valido  = ~vazia;
    assign db_estado      = expira ? DB_TIMEOUT : {2'b00, estado};

endmodule

// File: tb/tb_receptor_pedidos.sv
// Directed bench for receptor_pedidos; inputs driven on the falling edge, outputs read there too.
// Timeout scenario expectations follow FRAME_TIMEOUT_EN.
module tb_receptor_pedidos;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] rx_dado = 8'h00;
    logic       rx_pronto = 1'b0;
    logic [1:0] pedido_origem;
    logic [1:0] pedido_destino;
    logic       pedido_valido;
    logic       pedido_aceito = 1'b0;
    logic       fila_cheia;
    logic       erro_quadro;
    logic       fila_overflow;
    logic [7:0] num_erros;
    logic [3:0] db_estado;

    int total = 0;
    int bad = 0;

    always #5 clock = ~clock;

    receptor_pedidos #(
        .PROFUNDIDADE  (4),
        .ANDAR_MAX     (3),
        .TIMEOUT_CICLOS(20)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .rx_dado       (rx_dado),
        .rx_pronto     (rx_pronto),
        .pedido_origem (pedido_origem),
        .pedido_destino(pedido_destino),
        .pedido_valido (pedido_valido),
        .pedido_aceito (pedido_aceito),
        .fila_cheia    (fila_cheia),
        .erro_quadro   (erro_quadro),
        .fila_overflow (fila_overflow),
        .num_erros     (num_erros),
        .db_estado     (db_estado)
    );

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clock);
        rx_dado   = b;
        rx_pronto = 1'b1;
        @(negedge clock);
        rx_pronto = 1'b0;
    endtask

    task automatic send_frame(input logic [1:0] o, input logic [1:0] d);
        send_byte(8'h30 + {6'd0, o});
        send_byte(8'h30 + {6'd0, d});
        send_byte(8'h23);
    endtask

    task automatic pop_one();
        pedido_aceito = 1'b1;
        @(negedge clock);
        pedido_aceito = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset         = 1'b1;
        rx_pronto     = 1'b0;
        pedido_aceito = 1'b0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({pedido_valido, pedido_origem, pedido_destino, fila_cheia}
            !== 6'd0) begin
            bad++;
            $display("FAIL reset_fifo: got v=%b o=%0d d=%0d cheia=%b want 0",
                     pedido_valido, pedido_origem, pedido_destino, fila_cheia);
        end
        total++;
        if ({erro_quadro, fila_overflow, num_erros, db_estado} !== 14'd0) begin
            bad++;
            $display("FAIL reset_status: got erro=%b ovf=%b num=%0d db=%0d want 0",
                     erro_quadro, fila_overflow, num_erros, db_estado);
        end
    endtask

    task automatic test_frame_basico();
        do_reset();
        send_byte("1");
        total++;
        if (db_estado !== 4'd1) begin
            bad++;
            $display("FAIL basic_db1: got %0d want 1", db_estado);
        end
        idle(9);
        send_byte("3");
        total++;
        if (pedido_valido !== 1'b0 || db_estado !== 4'd2) begin
            bad++;
            $display("FAIL basic_mid: got v=%b db=%0d want v=0 db=2",
                     pedido_valido, db_estado);
        end
        idle(9);
        send_byte("#");
        total++;
        if (pedido_valido !== 1'b1 || pedido_origem !== 2'd1
            || pedido_destino !== 2'd3) begin
            bad++;
            $display("FAIL basic_head: got v=%b o=%0d d=%0d want v=1 o=1 d=3",
                     pedido_valido, pedido_origem, pedido_destino);
        end
        total++;
        if (erro_quadro !== 1'b0 || db_estado !== 4'd0) begin
            bad++;
            $display("FAIL basic_status: got erro=%b db=%0d want erro=0 db=0",
                     erro_quadro, db_estado);
        end
        pop_one();
        total++;
        if (pedido_valido !== 1'b0) begin
            bad++;
            $display("FAIL basic_pop: got v=%b want 0", pedido_valido);
        end
    endtask

    task automatic test_erros();
        do_reset();
        send_byte("2");
        send_byte("2");
        total++;
        if (erro_quadro !== 1'b1) begin
            bad++;
            $display("FAIL err_same_floor: got %b want 1", erro_quadro);
        end
        send_byte("#");
        total++;
        if (erro_quadro !== 1'b1 || db_estado !== 4'd0) begin
            bad++;
            $display("FAIL err_hash_origin: got erro=%b db=%0d want erro=1 db=0",
                     erro_quadro, db_estado);
        end
        idle(1);
        total++;
        if (erro_quadro !== 1'b0) begin
            bad++;
            $display("FAIL err_pulse_width: got %b want 0", erro_quadro);
        end
        send_byte("0");
        send_byte("x");
        send_byte("#");
        total++;
        if (num_erros !== 8'd4 || pedido_valido !== 1'b0) begin
            bad++;
            $display("FAIL err_count: got num=%0d v=%b want num=4 v=0",
                     num_erros, pedido_valido);
        end
        send_frame(2'd0, 2'd1);
        total++;
        if (pedido_valido !== 1'b1 || pedido_origem !== 2'd0
            || pedido_destino !== 2'd1 || num_erros !== 8'd4) begin
            bad++;
            $display("FAIL err_resync: got v=%b o=%0d d=%0d num=%0d want 1 0 1 4",
                     pedido_valido, pedido_origem, pedido_destino, num_erros);
        end
    endtask

    task automatic test_overflow();
        logic [1:0] fo[5];
        logic [1:0] fd[5];
        fo = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1};
        fd = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd0};
        do_reset();
        for (int i = 0; i < 3; i++)
            send_frame(fo[i], fd[i]);
        total++;
        if (fila_cheia !== 1'b0) begin
            bad++;
            $display("FAIL ovf_not_full: got %b want 0", fila_cheia);
        end
        send_frame(fo[3], fd[3]);
        total++;
        if (fila_cheia !== 1'b1) begin
            bad++;
            $display("FAIL ovf_full: got %b want 1", fila_cheia);
        end
        send_frame(fo[4], fd[4]);
        total++;
        if (fila_overflow !== 1'b1 || erro_quadro !== 1'b0
            || num_erros !== 8'd1) begin
            bad++;
            $display("FAIL ovf_pulse: got ovf=%b erro=%b num=%0d want 1 0 1",
                     fila_overflow, erro_quadro, num_erros);
        end
        idle(1);
        total++;
        if (fila_overflow !== 1'b0 || fila_cheia !== 1'b1) begin
            bad++;
            $display("FAIL ovf_after: got ovf=%b cheia=%b want 0 1",
                     fila_overflow, fila_cheia);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (pedido_valido !== 1'b1 || pedido_origem !== fo[i]
                || pedido_destino !== fd[i]) begin
                bad++;
                $display("FAIL ovf_drain%0d: got v=%b o=%0d d=%0d want 1 %0d %0d",
                         i, pedido_valido, pedido_origem, pedido_destino,
                         fo[i], fd[i]);
            end
            pop_one();
        end
        total++;
        if (pedido_valido !== 1'b0 || fila_cheia !== 1'b0) begin
            bad++;
            $display("FAIL ovf_empty: got v=%b cheia=%b want 0 0",
                     pedido_valido, fila_cheia);
        end
    endtask

    task automatic test_push_pop_cheio();
        logic [1:0] fo[5];
        logic [1:0] fd[5];
        fo = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2};
        fd = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd0};
        do_reset();
        for (int i = 0; i < 4; i++)
            send_frame(fo[i], fd[i]);
        send_byte("2");
        send_byte("0");
        @(negedge clock);
        rx_dado       = 8'h23;
        rx_pronto     = 1'b1;
        pedido_aceito = 1'b1;
        @(negedge clock);
        rx_pronto     = 1'b0;
        pedido_aceito = 1'b0;
        total++;
        if (fila_overflow !== 1'b0 || fila_cheia !== 1'b1
            || num_erros !== 8'd0) begin
            bad++;
            $display("FAIL pp_full: got ovf=%b cheia=%b num=%0d want 0 1 0",
                     fila_overflow, fila_cheia, num_erros);
        end
        for (int i = 1; i < 5; i++) begin
            total++;
            if (pedido_valido !== 1'b1 || pedido_origem !== fo[i]
                || pedido_destino !== fd[i]) begin
                bad++;
                $display("FAIL pp_drain%0d: got v=%b o=%0d d=%0d want 1 %0d %0d",
                         i, pedido_valido, pedido_origem, pedido_destino,
                         fo[i], fd[i]);
            end
            pop_one();
        end
        total++;
        if (pedido_valido !== 1'b0) begin
            bad++;
            $display("FAIL pp_empty: got v=%b want 0", pedido_valido);
        end
    endtask

    task automatic test_reset_meio();
        do_reset();
        send_frame(2'd1, 2'd0);
        send_frame(2'd2, 2'd1);
        send_byte("1");
        send_byte("2");
        @(negedge clock);
        reset         = 1'b1;
        pedido_aceito = 1'b1;
        @(negedge clock);
        reset         = 1'b0;
        pedido_aceito = 1'b0;
        total++;
        if ({pedido_valido, pedido_origem, pedido_destino, fila_cheia,
             erro_quadro, fila_overflow, num_erros, db_estado} !== 20'd0) begin
            bad++;
            $display("FAIL midreset: got v=%b o=%0d d=%0d c=%b e=%b ov=%b n=%0d db=%0d",
                     pedido_valido, pedido_origem, pedido_destino, fila_cheia,
                     erro_quadro, fila_overflow, num_erros, db_estado);
        end
        send_frame(2'd3, 2'd0);
        total++;
        if (pedido_valido !== 1'b1 || pedido_origem !== 2'd3
            || pedido_destino !== 2'd0 || num_erros !== 8'd0) begin
            bad++;
            $display("FAIL midreset_new: got v=%b o=%0d d=%0d num=%0d want 1 3 0 0",
                     pedido_valido, pedido_origem, pedido_destino, num_erros);
        end
        pop_one();
        total++;
        if (pedido_valido !== 1'b0) begin
            bad++;
            $display("FAIL midreset_single: got v=%b want 0", pedido_valido);
        end
    endtask

    task automatic test_timeout();
        int pulsos = 0;
        int db3 = 0;
        do_reset();
        send_byte("1");
        for (int i = 0; i < 22; i++) begin
            @(negedge clock);
            if (erro_quadro === 1'b1)
                pulsos++;
            if (db_estado === 4'd3)
                db3++;
        end
`ifdef FRAME_TIMEOUT_EN
        total++;
        if (pulsos !== 1 || db3 !== 1 || db_estado !== 4'd0) begin
            bad++;
            $display("FAIL timeout_fire: got pulses=%0d db3=%0d db=%0d want 1 1 0",
                     pulsos, db3, db_estado);
        end
        send_frame(2'd2, 2'd0);
        total++;
        if (pedido_valido !== 1'b1 || pedido_origem !== 2'd2
            || pedido_destino !== 2'd0 || num_erros !== 8'd1) begin
            bad++;
            $display("FAIL timeout_next: got v=%b o=%0d d=%0d num=%0d want 1 2 0 1",
                     pedido_valido, pedido_origem, pedido_destino, num_erros);
        end
`else
        total++;
        if (pulsos !== 0 || db3 !== 0 || db_estado !== 4'd1) begin
            bad++;
            $display("FAIL notimeout_wait: got pulses=%0d db3=%0d db=%0d want 0 0 1",
                     pulsos, db3, db_estado);
        end
        send_byte("2");
        send_byte("#");
        total++;
        if (pedido_valido !== 1'b1 || pedido_origem !== 2'd1
            || pedido_destino !== 2'd2 || num_erros !== 8'd0) begin
            bad++;
            $display("FAIL notimeout_frame: got v=%b o=%0d d=%0d num=%0d want 1 1 2 0",
                     pedido_valido, pedido_origem, pedido_destino, num_erros);
        end
`endif
    endtask

    task automatic test_saturacao();
        do_reset();
        repeat (254) send_byte("#");
        total++;
        if (num_erros !== 8'd254) begin
            bad++;
            $display("FAIL sat_254: got %0d want 254", num_erros);
        end
        repeat (6) send_byte("#");
        total++;
        if (num_erros !== 8'd255) begin
            bad++;
            $display("FAIL sat_hold: got %0d want 255", num_erros);
        end
    endtask

    initial begin
        test_reset();
        test_frame_basico();
        test_erros();
        test_overflow();
        test_push_pop_cheio();
        test_reset_meio();
        test_timeout();
        test_saturacao();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
